// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states, default slot length and the
// word-select channel encoding used by the receiver, clock generator and TX.
package i2s_pkg;

    localparam int I2S_SLOT_WIDTH = 32;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2
    } i2s_rx_state_e;

    // Level of the word-select line for each channel.
    typedef enum logic {
        I2S_LEFT  = 1'b0,
        I2S_RIGHT = 1'b1
    } i2s_chan_e;

endpackage

// File: rtl/i2s_rx_slave_if.sv
// Sample-pair stream from the I2S receiver to downstream DSP/FIFO logic.
//   left_o / right_o : held stereo pair
//   valid_o          : pair available
//   ready_i          : consumer takes the pair when valid_o && ready_i
// master = producer (receiver), slave = consumer.
interface i2s_rx_slave_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic [SAMPLE_WIDTH-1:0] left_o;
    logic [SAMPLE_WIDTH-1:0] right_o;
    logic                    valid_o;
    logic                    ready_i;

    modport master (output left_o, output right_o, output valid_o, input ready_i);
    modport slave  (input left_o, input right_o, input valid_o, output ready_i);
endinterface

// File: rtl/i2s_sync_edge.sv
// Multi-bit input synchroniser with a rising-edge detector on bit 0.
//   clk  : sampling clock
//   rst  : synchronous reset, active-high
//   d    : asynchronous inputs (bit 0 is the clock to edge-detect)
//   sync : synchronised levels, STAGES cycles behind d
//   rise : one-cycle pulse when sync[0] goes 0 -> 1
module i2s_sync_edge #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sync,
    output logic             rise
);

    logic [WIDTH-1:0] chain [STAGES];
    logic             dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
            dly <= 1'b0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            dly <= chain[STAGES-1][0];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync[0] & ~dly;

endmodule

// File: rtl/i2s_rx_slave.sv
// I2S (Philips format) slave receiver. Synchronises external BCLK/LRCLK/SD
// into clk_i, deserialises stereo frames and hands L/R pairs downstream.
// clk_i must run at least 4x BCLK.
//   clk_i, rst_i      : system clock, synchronous active-high reset
//   enable_i          : low = flush to resync, clear valid/overrun
//   bclk_i, lrclk_i, sd_i : asynchronous I2S inputs (lrclk 0 = left)
//   pair              : left/right/valid/ready sample-pair stream
//   overrun_o         : sticky, a completed pair was dropped
//   frame_err_o       : one-cycle pulse on a short or long slot
module i2s_rx_slave
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           enable_i,
    input  logic           bclk_i,
    input  logic           lrclk_i,
    input  logic           sd_i,
    i2s_rx_slave_if.master pair,
    output logic           overrun_o,
    output logic           frame_err_o
);

    localparam int IDX_W = $clog2(SLOT_WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_SLOT = IDX_W'(SLOT_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LSB  = IDX_W'(SAMPLE_WIDTH);

    logic [2:0] in_sync;
    logic       bclk_rise;
    logic       unused_bclk_level;

    i2s_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .d    ({sd_i, lrclk_i, bclk_i}),
        .sync (in_sync),
        .rise (bclk_rise)
    );
    assign unused_bclk_level = in_sync[0];

    // Edge and the lrclk/sd levels seen at that edge, registered together.
    logic edge_q, lr_q, sd_q, lr_prev;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [SAMPLE_WIDTH-1:0] shift, shift_nxt, left_hold, pair_left, pair_right;
    logic [SAMPLE_WIDTH-1:0] out_left, out_right;
    logic out_valid, pair_done;
    i2s_rx_state_e state, state_nxt;
    logic lr_chg, sample_bit, frame_err, left_latch, pair_complete;

    assign lr_chg     = edge_q && (lr_q != lr_prev);
    assign idx_nxt    = lr_chg ? '0 : ((idx == IDX_SLOT) ? idx : idx + 1'b1);
    // idx 0 carries the previous word's LSB (one-bit I2S delay).
    assign sample_bit = (idx_nxt != '0) && (idx_nxt <= IDX_LSB);
    assign shift_nxt  = {shift[SAMPLE_WIDTH-2:0], sd_q};

    always_comb begin
        state_nxt     = state;
        frame_err     = 1'b0;
        left_latch    = 1'b0;
        pair_complete = 1'b0;
        if (edge_q && enable_i) begin
            case (state)
                RESYNC: begin
                    if (lr_chg && lr_q == I2S_LEFT) state_nxt = LEFT;
                end
                LEFT, RIGHT: begin
                    if (lr_chg) begin
                        if (idx < IDX_LSB) begin
                            frame_err = 1'b1;
                            // A 1->0 change also re-arms on the same edge.
                            state_nxt = (lr_q == I2S_LEFT) ? LEFT : RESYNC;
                        end else begin
                            state_nxt = (state == LEFT) ? RIGHT : LEFT;
                        end
                    end else if (idx_nxt == IDX_SLOT) begin
                        frame_err = 1'b1;
                        state_nxt = RESYNC;
                    end else if (idx_nxt == IDX_LSB) begin
                        if (state == LEFT) left_latch    = 1'b1;
                        else               pair_complete = 1'b1;
                    end
                end
                default: state_nxt = RESYNC;
            endcase
        end
        if (!enable_i) state_nxt = RESYNC;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_q      <= 1'b0;
            lr_q        <= 1'b0;
            sd_q        <= 1'b0;
            lr_prev     <= 1'b0;
            idx         <= '0;
            state       <= RESYNC;
            shift       <= '0;
            left_hold   <= '0;
            pair_left   <= '0;
            pair_right  <= '0;
            pair_done   <= 1'b0;
            out_left    <= '0;
            out_right   <= '0;
            out_valid   <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            edge_q      <= bclk_rise;
            lr_q        <= in_sync[1];
            sd_q        <= in_sync[2];
            state       <= state_nxt;
            frame_err_o <= frame_err;
            pair_done   <= pair_complete;
            // Track lrclk even while disabled so re-enable sees no stale change.
            if (edge_q) lr_prev <= lr_q;
            if (!enable_i)   idx <= '0;
            else if (edge_q) idx <= idx_nxt;
            if (edge_q && enable_i && sample_bit) shift <= shift_nxt;
            if (left_latch) left_hold <= shift_nxt;
            if (pair_complete) begin
                pair_left  <= left_hold;
                pair_right <= shift_nxt;
            end

            if (!enable_i) begin
                out_valid <= 1'b0;
                overrun_o <= 1'b0;
            end else if (pair_done) begin
                if (!out_valid || pair.ready_i) begin
                    out_left  <= pair_left;
                    out_right <= pair_right;
                    out_valid <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (out_valid && pair.ready_i) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign pair.left_o  = out_left;
    assign pair.right_o = out_right;
    assign pair.valid_o = out_valid;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Directed bench for i2s_rx_slave: a BCLK = clk/14 I2S master model with
// hand-chosen sample pairs; a negedge monitor counts accepted pairs and
// frame-error pulses, and the directed steps compare against constants.
module tb_i2s_rx_slave;
    import i2s_pkg::*;

    localparam int SW = 24;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic sd = 1'b0;
    logic overrun, frame_err;

    i2s_rx_slave_if #(.SAMPLE_WIDTH(SW)) pair_if ();

    i2s_rx_slave #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(32), .SYNC_STAGES(SS)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .bclk_i      (bclk),
        .lrclk_i     (lrclk),
        .sd_i        (sd),
        .pair        (pair_if),
        .overrun_o   (overrun),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int err_cnt = 0;
    logic [SW-1:0] acc_l = '0;
    logic [SW-1:0] acc_r = '0;

    always @(negedge clk) begin
        if (pair_if.valid_o && pair_if.ready_i) begin
            acc_cnt = acc_cnt + 1;
            acc_l = pair_if.left_o;
            acc_r = pair_if.right_o;
        end
        if (frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic lr, input logic b);
        bclk = 1'b0; lrclk = lr; sd = b;
        tick_n(7);
        bclk = 1'b1;
        tick_n(7);
    endtask

    // Slot position k: 0 = previous word's LSB (sent as 0), 1..24 = MSB..LSB, rest padding.
    function automatic logic slot_bit(input logic [SW-1:0] w, input int k);
        return (k >= 1 && k <= SW) ? w[SW-k] : 1'b0;
    endfunction

    task automatic send_slot(input logic lr, input logic [SW-1:0] w, input int from, input int to);
        for (int k = from; k < to; k++) send_bit(lr, slot_bit(w, k));
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        send_slot(1'b0, l, 0, 32);
        send_slot(1'b1, r, 0, 32);
    endtask

    int acc0, err0;

    initial begin
        pair_if.ready_i = 1'b1;
        tick_n(3);
        check("rst_valid", {31'd0, pair_if.valid_o}, 32'd0);
        check("rst_left", {8'd0, pair_if.left_o}, 32'd0);
        check("rst_right", {8'd0, pair_if.right_o}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;

        // 1: first full frame after resync, with output latency probe
        acc0 = acc_cnt; err0 = err_cnt;
        send_slot(1'b1, 24'hFFFFFF, 0, 32);
        send_slot(1'b0, 24'h123456, 0, 32);
        send_slot(1'b1, 24'hABCDEF, 0, SW);
        bclk = 1'b0; lrclk = 1'b1; sd = 1'b1;   // LSB of 24'hABCDEF
        tick_n(7);
        bclk = 1'b1;
        tick_n(SS + 2);
        check("t1_latency_early", {31'd0, pair_if.valid_o}, 32'd0);
        tick();
        check("t1_latency_valid", {31'd0, pair_if.valid_o}, 32'd1);
        check("t1_left", {8'd0, pair_if.left_o}, 32'h123456);
        check("t1_right", {8'd0, pair_if.right_o}, 32'hABCDEF);
        tick();
        check("t1_valid_drop", {31'd0, pair_if.valid_o}, 32'd0);
        tick_n(7 - (SS + 4));
        send_slot(1'b1, 24'hABCDEF, SW + 1, 32);
        check("t1_pairs", acc_cnt - acc0, 32'd1);
        check("t1_errs", err_cnt - err0, 32'd0);

        // 2: back-pressure and overrun
        pair_if.ready_i = 1'b0;
        send_frame(24'h111111, 24'h222222);
        check("t2_held_valid", {31'd0, pair_if.valid_o}, 32'd1);
        check("t2_held_left", {8'd0, pair_if.left_o}, 32'h111111);
        check("t2_no_overrun", {31'd0, overrun}, 32'd0);
        send_frame(24'h333333, 24'h444444);
        check("t2_overrun", {31'd0, overrun}, 32'd1);
        send_frame(24'h555555, 24'h666666);
        check("t2_f3_left", {8'd0, pair_if.left_o}, 32'h111111);
        check("t2_f3_right", {8'd0, pair_if.right_o}, 32'h222222);
        acc0 = acc_cnt;
        pair_if.ready_i = 1'b1;
        tick();
        check("t2_accept", acc_cnt - acc0, 32'd1);
        check("t2_acc_left", {8'd0, acc_l}, 32'h111111);
        check("t2_acc_right", {8'd0, acc_r}, 32'h222222);
        check("t2_valid_drop", {31'd0, pair_if.valid_o}, 32'd0);
        check("t2_overrun_sticky", {31'd0, overrun}, 32'd1);

        // 3: streaming starts in the middle of a right slot
        rst = 1'b1; tick(); rst = 1'b0;
        check("t3_overrun_rst", {31'd0, overrun}, 32'd0);
        acc0 = acc_cnt; err0 = err_cnt;
        send_slot(1'b1, 24'hF0F0F0, 10, 32);
        send_slot(1'b0, 24'hC0FFEE, 0, 32);
        check("t3_no_early", acc_cnt - acc0, 32'd0);
        send_slot(1'b1, 24'h0BADF0, 0, 32);
        check("t3_pairs", acc_cnt - acc0, 32'd1);
        check("t3_left", {8'd0, acc_l}, 32'hC0FFEE);
        check("t3_right", {8'd0, acc_r}, 32'h0BADF0);
        check("t3_errs", err_cnt - err0, 32'd0);

        // 4: left slot cut to 10 BCLKs
        acc0 = acc_cnt; err0 = err_cnt;
        send_slot(1'b0, 24'hFFFFFF, 0, 10);
        send_slot(1'b1, 24'hFFFFFF, 0, 32);
        check("t4_err_pulse", err_cnt - err0, 32'd1);
        check("t4_no_pair", acc_cnt - acc0, 32'd0);
        send_frame(24'h765432, 24'h89ABCD);
        check("t4_pairs", acc_cnt - acc0, 32'd1);
        check("t4_left", {8'd0, acc_l}, 32'h765432);
        check("t4_right", {8'd0, acc_r}, 32'h89ABCD);

        // 5: one-cycle reset in the middle of a left word
        pair_if.ready_i = 1'b0;
        send_frame(24'hA5A5A5, 24'h5A5A5A);
        check("t5_held_left", {8'd0, pair_if.left_o}, 32'hA5A5A5);
        send_slot(1'b0, 24'h999999, 0, 12);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_valid", {31'd0, pair_if.valid_o}, 32'd0);
        check("t5_left", {8'd0, pair_if.left_o}, 32'd0);
        check("t5_right", {8'd0, pair_if.right_o}, 32'd0);
        send_slot(1'b0, 24'h999999, 12, 32);
        send_slot(1'b1, 24'h888888, 0, 32);
        pair_if.ready_i = 1'b1;
        acc0 = acc_cnt;
        send_frame(24'h13579B, 24'h2468AC);
        check("t5_pairs", acc_cnt - acc0, 32'd1);
        check("t5_acc_left", {8'd0, acc_l}, 32'h13579B);
        check("t5_acc_right", {8'd0, acc_r}, 32'h2468AC);

        // 6: disable during a right slot with overrun set
        pair_if.ready_i = 1'b0;
        send_frame(24'h010203, 24'h040506);
        send_frame(24'h070809, 24'h0A0B0C);
        check("t6_overrun_set", {31'd0, overrun}, 32'd1);
        send_slot(1'b0, 24'h777777, 0, 32);
        send_slot(1'b1, 24'h777777, 0, 10);
        enable = 1'b0;
        tick();
        check("t6_overrun_clr", {31'd0, overrun}, 32'd0);
        check("t6_valid_clr", {31'd0, pair_if.valid_o}, 32'd0);
        send_slot(1'b1, 24'h777777, 10, 20);
        acc0 = acc_cnt;
        enable = 1'b1;
        pair_if.ready_i = 1'b1;
        send_slot(1'b1, 24'h777777, 20, 32);
        check("t6_no_pair_before_resync", acc_cnt - acc0, 32'd0);
        send_frame(24'hDEAD01, 24'hBEEF02);
        check("t6_pairs", acc_cnt - acc0, 32'd1);
        check("t6_left", {8'd0, acc_l}, 32'hDEAD01);
        check("t6_right", {8'd0, acc_r}, 32'hBEEF02);

        // 7: shortest legal slot (LSB is the last bit)
        acc0 = acc_cnt; err0 = err_cnt;
        send_slot(1'b0, 24'h314159, 0, SW + 1);
        send_slot(1'b1, 24'h271828, 0, 32);
        check("t7_errs", err_cnt - err0, 32'd0);
        check("t7_pairs", acc_cnt - acc0, 32'd1);
        check("t7_left", {8'd0, acc_l}, 32'h314159);
        check("t7_right", {8'd0, acc_r}, 32'h271828);

        // 8: one bit short of the shortest legal slot
        acc0 = acc_cnt; err0 = err_cnt;
        send_slot(1'b0, 24'h314159, 0, SW);
        send_slot(1'b1, 24'h271828, 0, 32);
        check("t8_errs", err_cnt - err0, 32'd1);
        check("t8_no_pair", acc_cnt - acc0, 32'd0);

        // 9: 33-bit left slot is too long
        acc0 = acc_cnt; err0 = err_cnt;
        send_slot(1'b0, 24'h112233, 0, 33);
        send_slot(1'b1, 24'h445566, 0, 32);
        check("t9_errs", err_cnt - err0, 32'd1);
        check("t9_no_pair", acc_cnt - acc0, 32'd0);
        send_frame(24'hFEDCBA, 24'h012345);
        check("t9_pairs", acc_cnt - acc0, 32'd1);
        check("t9_left", {8'd0, acc_l}, 32'hFEDCBA);

        // 10: short right slot errors and re-arms on the same 1->0 edge
        acc0 = acc_cnt; err0 = err_cnt;
        send_slot(1'b0, 24'h000111, 0, 32);
        send_slot(1'b1, 24'h000222, 0, 10);
        send_frame(24'h600DF0, 24'h0D0D0D);
        check("t10_errs", err_cnt - err0, 32'd1);
        check("t10_pairs", acc_cnt - acc0, 32'd1);
        check("t10_left", {8'd0, acc_l}, 32'h600DF0);
        check("t10_right", {8'd0, acc_r}, 32'h0D0D0D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
